// File: rtl/garage_door_sequencer_if.sv
// garage_door_sequencer_if: command/limit/motor bundle between the door sequencer and its surroundings
// Signals:
//   req      source -> sequencer  per-source activate level (N_REQ bits)
//   up_max   source -> sequencer  door fully open limit
//   dn_max   source -> sequencer  door fully closed limit
//   obstruct source -> sequencer  beam-break sensor, 1 = blocked
//   up_m     sequencer -> source  open motor drive
//   dn_m     sequencer -> source  close motor drive
//   gnt      sequencer -> source  one-hot grant pulse (N_REQ bits)
//   busy     sequencer -> source  door in motion
//   fault    sequencer -> source  sticky watchdog/limit fault
interface garage_door_sequencer_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             up_max;
    logic             dn_max;
    logic             obstruct;
    logic             up_m;
    logic             dn_m;
    logic             busy;
    logic             fault;
    modport master (output req, up_max, dn_max, obstruct, input up_m, dn_m, gnt, busy, fault);
    modport slave (input req, up_max, dn_max, obstruct, output up_m, dn_m, gnt, busy, fault);
endinterface

// File: rtl/garage_door_sequencer.sv
// garage_door_sequencer: round-robin multi-source door command sequencer with stop, reversal, watchdog and dwell
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   door   slave side of garage_door_sequencer_if (req/limits/obstruct in, motors/gnt/busy/fault out)
module garage_door_sequencer #(
    parameter int N_REQ      = 4,
    parameter int MAX_TRAVEL = 200,
    parameter int DWELL      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    garage_door_sequencer_if.slave      door
);
    localparam int PW = $clog2(N_REQ);
    localparam int TW = $clog2(MAX_TRAVEL + 1);
    localparam int DW = $clog2(DWELL + 1);
    typedef enum logic [1:0] {IDLE, OPENING, CLOSING, FAULT} state_t;
    state_t           state_q, state_d;
    logic [N_REQ-1:0] req_prev_q, pend_q, pend_d, gnt_q, gnt_d, rise;
    logic [PW-1:0]    rr_q, rr_d, win, idx;
    logic             last_up_q, last_up_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [TW-1:0]    travel_q, travel_d;
    logic             grant, both, open_tgt, wd;
    // Scan downward so the last hit is the first pending index at or after rr_q.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = PW'((int'(rr_q) + k) % N_REQ);
            if (pend_q[idx]) win = idx;
        end
    end
    always_comb begin
        rise      = door.req & ~req_prev_q;
        both      = door.up_max & door.dn_max;
        // A reversing close swallows the grant slot; pending presses wait.
        grant     = (|pend_q) && state_q != FAULT && !both && !(state_q == CLOSING && door.obstruct)
                    && (state_q != IDLE || dwell_q == '0);
        open_tgt  = door.dn_max || (!door.up_max && !last_up_q);
        wd        = travel_q == TW'(MAX_TRAVEL - 1);
        state_d   = state_q;
        last_up_d = last_up_q;
        travel_d  = travel_q;
        dwell_d   = (dwell_q != '0) ? dwell_q - 1'b1 : '0;
        if (both) state_d = FAULT;
        else case (state_q)
            IDLE: if (grant && (open_tgt || !door.obstruct)) begin
                state_d  = open_tgt ? OPENING : CLOSING;
                travel_d = '0;
            end
            OPENING: if (door.up_max || grant) begin
                state_d   = IDLE;
                last_up_d = 1'b1;
                dwell_d   = DW'(DWELL);
            end else begin
                state_d  = wd ? FAULT : OPENING;
                travel_d = travel_q + 1'b1;
            end
            CLOSING: if (door.obstruct) begin
                state_d  = OPENING;
                travel_d = '0;
            end else if (door.dn_max || grant) begin
                state_d   = IDLE;
                last_up_d = 1'b0;
                dwell_d   = DW'(DWELL);
            end else begin
                state_d  = wd ? FAULT : CLOSING;
                travel_d = travel_q + 1'b1;
            end
            default: state_d = FAULT;
        endcase
        // A grant clears every pending bit; only edges arriving this very cycle survive.
        pend_d = (state_q == FAULT || state_d == FAULT) ? '0 : grant ? rise : (pend_q | rise);
        gnt_d  = grant ? (N_REQ'(1) << win) : '0;
        rr_d   = grant ? ((win == PW'(N_REQ - 1)) ? '0 : win + 1'b1) : rr_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_prev_q <= '0;
            pend_q     <= '0;
            gnt_q      <= '0;
            rr_q       <= '0;
            last_up_q  <= 1'b0;
            dwell_q    <= '0;
            travel_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_prev_q <= door.req;
            pend_q     <= pend_d;
            gnt_q      <= gnt_d;
            rr_q       <= rr_d;
            last_up_q  <= last_up_d;
            dwell_q    <= dwell_d;
            travel_q   <= travel_d;
        end
    end
    assign door.up_m  = state_q == OPENING;
    assign door.dn_m  = state_q == CLOSING;
    assign door.busy  = state_q == OPENING || state_q == CLOSING;
    assign door.fault = state_q == FAULT;
    assign door.gnt   = gnt_q;
endmodule

// File: tb/tb_garage_door_sequencer.sv
// tb_garage_door_sequencer: randomized and directed stimulus against a behavioural door model
module tb_garage_door_sequencer;
    localparam int N  = 4;
    localparam int MT = 200;
    localparam int DW = 8;
    localparam int P  = 30;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    garage_door_sequencer_if #(.N_REQ(N)) door();
    garage_door_sequencer #(.N_REQ(N), .MAX_TRAVEL(MT), .DWELL(DW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .door(door)
    );
    int n_chk = 0;
    int n_fail = 0;
    // Model: direction as +1/-1/0, ages counted upward in cycles.
    int         m_dir, m_last, m_rr, idle_age, moved;
    bit         m_fault;
    logic [N-1:0] m_pend, m_prev, e_gnt, rnd;
    int         pos = 0;
    bit         nolim = 1'b0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_dir = 0; m_last = -1; m_rr = 0; idle_age = 1000; moved = 0;
        m_fault = 1'b0; m_pend = '0; m_prev = '0; e_gnt = '0;
    endtask
    task automatic model_step();
        logic [N-1:0] rise;
        bit g;
        int w, tgt;
        g = 1'b0; w = 0;
        rise = door.req & ~m_prev;
        m_prev = door.req;
        if (idle_age < 1000) idle_age++;
        e_gnt = '0;
        if (m_fault) begin
            m_pend = '0;
            return;
        end
        if (m_pend != '0 && !(door.up_max && door.dn_max) && !(m_dir == -1 && door.obstruct)
            && (m_dir != 0 || idle_age > DW)) begin
            for (int k = 0; k < N; k++)
                if (!g && m_pend[(m_rr + k) % N]) begin g = 1'b1; w = (m_rr + k) % N; end
            e_gnt[w] = 1'b1;
            m_rr = (w + 1) % N;
            m_pend = rise;
        end else m_pend = m_pend | rise;
        if (door.up_max && door.dn_max) begin
            m_fault = 1'b1; m_dir = 0;
        end else if (m_dir == 0) begin
            if (g) begin
                tgt = door.dn_max ? 1 : door.up_max ? -1 : -m_last;
                if (tgt == 1 || !door.obstruct) begin m_dir = tgt; moved = 0; end
            end
        end else if (m_dir == -1 && door.obstruct) begin
            m_dir = 1; moved = 0;
        end else if ((m_dir == 1 && door.up_max) || (m_dir == -1 && door.dn_max) || g) begin
            m_last = m_dir; m_dir = 0; idle_age = 0;
        end else begin
            moved++;
            if (moved == MT) begin m_fault = 1'b1; m_dir = 0; end
        end
        if (m_fault) m_pend = '0;
    endtask
    task automatic check_all();
        check("up_m", {31'b0, door.up_m}, {31'b0, m_dir == 1});
        check("dn_m", {31'b0, door.dn_m}, {31'b0, m_dir == -1});
        check("busy", {31'b0, door.busy}, {31'b0, m_dir != 0});
        check("fault", {31'b0, door.fault}, {31'b0, m_fault});
        check("gnt", {28'b0, door.gnt}, {28'b0, e_gnt});
    endtask
    task automatic drive_limits();
        door.up_max = !nolim && pos >= P;
        door.dn_max = !nolim && pos <= 0;
    endtask
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        @(negedge clk);
        check_all();
        pos += m_dir;
        if (pos < 0) pos = 0;
        if (pos > P) pos = P;
        drive_limits();
    endtask
    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask
    task automatic press(input logic [N-1:0] m);
        door.req = m;
        tick();
        door.req = '0;
        tick();
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        rst_n = 1'b1;
    endtask
    initial begin
        door.req = '0;
        door.obstruct = 1'b0;
        drive_limits();
        model_reset();
        @(negedge clk);
        do_reset();
        // Open from closed via source 2.
        press(4'b0100);
        check("gnt_first", {28'b0, door.gnt}, 32'h4);
        check("up_first", {31'b0, door.up_m}, 32'h1);
        tick();
        check("gnt_one_cycle", {28'b0, door.gnt}, 32'h0);
        run(P + 2);
        check("open_arrive_up", {31'b0, door.up_m}, 32'h0);
        check("open_arrive_busy", {31'b0, door.busy}, 32'h0);
        // Simultaneous presses coalesce; round-robin moves on.
        do_reset();
        press(4'b1001);
        check("coalesce_gnt", {28'b0, door.gnt}, 32'h1);
        check("coalesce_dn", {31'b0, door.dn_m}, 32'h1);
        run(P + DW + 4);
        press(4'b1001);
        check("rr_gnt", {28'b0, door.gnt}, 32'h8);
        run(P + DW + 4);
        // Close, then reverse on obstruction.
        press(4'b0001);
        run(20);
        door.obstruct = 1'b1;
        tick();
        door.obstruct = 1'b0;
        check("rev_up", {31'b0, door.up_m}, 32'h1);
        check("rev_dn", {31'b0, door.dn_m}, 32'h0);
        check("rev_gnt", {28'b0, door.gnt}, 32'h0);
        // Press-to-stop mid-travel, second press held through dwell.
        run(3);
        press(4'b0010);
        check("press_stop", {31'b0, door.up_m}, 32'h0);
        run(2);
        door.req = 4'b0010;
        tick();
        door.req = '0;
        run(4);
        check("dwell_hold", {31'b0, door.dn_m}, 32'h0);
        run(2);
        check("dwell_release", {31'b0, door.dn_m}, 32'h1);
        // Asynchronous reset while closing.
        run(3);
        rst_n = 1'b0;
        #1;
        check("rst_async_dn", {31'b0, door.dn_m}, 32'h0);
        model_reset();
        tick();
        rst_n = 1'b1;
        nolim = 1'b1;
        drive_limits();
        press(4'b0001);
        check("post_rst_open", {31'b0, door.up_m}, 32'h1);
        // Watchdog: no limit ever arrives.
        run(MT + 2);
        check("wd_fault", {31'b0, door.fault}, 32'h1);
        check("wd_motor", {30'b0, door.up_m, door.dn_m}, 32'h0);
        press(4'b1000);
        run(2);
        check("fault_no_gnt", {28'b0, door.gnt}, 32'h0);
        check("fault_sticky", {31'b0, door.fault}, 32'h1);
        nolim = 1'b0;
        drive_limits();
        do_reset();
        check("fault_cleared", {31'b0, door.fault}, 32'h0);
        // Random traffic against the door plant.
        for (int c = 0; c < 3000; c++) begin
            rnd = door.req;
            for (int i = 0; i < N; i++)
                rnd[i] = rnd[i] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 24) == 0);
            door.req = rnd;
            door.obstruct = $urandom_range(0, 49) == 0;
            tick();
        end
        door.req = '0;
        door.obstruct = 1'b0;
        run(2);
        door.up_max = 1'b1;
        door.dn_max = 1'b1;
        tick();
        check("both_limits_fault", {31'b0, door.fault}, 32'h1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
